// File: rtl/sm83_alu_flags.sv
// SM83 flag register file: Z/N/H/C flags, primary carry buffer for chained
// 16-bit arithmetic, and ALU carry-in selection.
module sm83_alu_flags #(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] alu_res,
    input  logic                 alu_cout,
    input  logic                 alu_hcout,
    input  logic                 shift_out,
    input  logic                 daa_carry_out,
    input  logic [WORD_SIZE-1:0] dbus,
    input  logic                 flags_load,
    input  logic [3:0]           flags_we,
    input  logic                 z_clr,
    input  logic                 n_val,
    input  logic [1:0]           h_src,
    input  logic [2:0]           c_src,
    input  logic                 pri_we,
    input  logic                 pri_clr,
    input  logic [1:0]           cin_sel,
    output logic                 alu_cin,
    output logic                 zero,
    output logic                 carry,
    output logic                 pri_carry,
    output logic                 daa_carry,
    output logic [WORD_SIZE-1:0] flags_out
);

    logic z_q, n_q, h_q, c_q, pri_q;
    logic z_d, n_d, h_d, c_d, pri_d;
    logic z_wr, h_wr, c_wr;

    // Only dbus[7:4] carries the flag image; the rest is ignored.
    logic dbus_unused;
    assign dbus_unused = ^dbus;

    // Per-flag write values selected from the ALU status and control sources.
    always_comb begin
        z_wr = (alu_res == '0) && !z_clr;
        h_wr = 1'b0;
        c_wr = c_q;
        case (h_src)
            2'd0: h_wr = alu_hcout;
            2'd1: h_wr = 1'b0;
            2'd2: h_wr = 1'b1;
            2'd3: h_wr = !alu_hcout;
            default: h_wr = 1'b0;
        endcase
        case (c_src)
            3'd0: c_wr = alu_cout;
            3'd1: c_wr = !alu_cout;
            3'd2: c_wr = shift_out;
            3'd3: c_wr = daa_carry_out | c_q;
            3'd4: c_wr = !c_q;
            3'd5: c_wr = 1'b1;
            default: c_wr = c_q;
        endcase
    end

    // Next-state: POP AF image wins over per-flag enables; primary carry is independent.
    always_comb begin
        z_d = z_q;
        n_d = n_q;
        h_d = h_q;
        c_d = c_q;
        if (flags_load) begin
            {z_d, n_d, h_d, c_d} = dbus[7:4];
        end else begin
            if (flags_we[3]) z_d = z_wr;
            if (flags_we[2]) n_d = n_val;
            if (flags_we[1]) h_d = h_wr;
            if (flags_we[0]) c_d = c_wr;
        end
        pri_d = pri_q;
        if (pri_clr) begin
            pri_d = 1'b0;
        end else if (pri_we) begin
            pri_d = alu_cout;
        end
    end

    // Flag and primary carry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            h_q   <= 1'b0;
            c_q   <= 1'b0;
            pri_q <= 1'b0;
        end else begin
            z_q   <= z_d;
            n_q   <= n_d;
            h_q   <= h_d;
            c_q   <= c_d;
            pri_q <= pri_d;
        end
    end

    // Carry-in mux straight from registered state, no added latency.
    always_comb begin
        alu_cin = 1'b0;
        case (cin_sel)
            2'd0: alu_cin = 1'b0;
            2'd1: alu_cin = c_q;
            2'd2: alu_cin = pri_q;
            2'd3: alu_cin = 1'b1;
            default: alu_cin = 1'b0;
        endcase
    end

    // Flag byte image; the low nibble is hard-wired to zero.
    always_comb begin
        flags_out      = '0;
        flags_out[7:4] = {z_q, n_q, h_q, c_q};
    end

    assign zero      = z_q;
    assign carry     = c_q;
    assign pri_carry = pri_q;
    assign daa_carry = h_q;

endmodule

// File: tb/tb_sm83_alu_flags.sv
// Scoreboard bench for sm83_alu_flags: driver pushes model expectations,
// monitors pop and compare against the DUT.
module tb_sm83_alu_flags;

    typedef struct packed {
        logic       rst;
        logic [7:0] res;
        logic       cout;
        logic       hcout;
        logic       sh;
        logic       daa;
        logic [7:0] dbus;
        logic       load;
        logic [3:0] we;
        logic       zc;
        logic       nv;
        logic [1:0] hs;
        logic [2:0] cs;
        logic       pwe;
        logic       pclr;
        logic [1:0] cin;
    } stim_t;

    typedef struct packed {
        logic [3:0] f;       // {Z,N,H,C} after the edge
        logic       pri;
        logic [3:0] gmask;   // spec-derived golden bits to check
        logic [3:0] gval;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] alu_res = '0;
    logic       alu_cout = 1'b0, alu_hcout = 1'b0, shift_out = 1'b0, daa_carry_out = 1'b0;
    logic [7:0] dbus = '0;
    logic       flags_load = 1'b0;
    logic [3:0] flags_we = '0;
    logic       z_clr = 1'b0, n_val = 1'b0;
    logic [1:0] h_src = '0;
    logic [2:0] c_src = '0;
    logic       pri_we = 1'b0, pri_clr = 1'b0;
    logic [1:0] cin_sel = '0;
    logic       alu_cin, zero, carry, pri_carry, daa_carry;
    logic [7:0] flags_out;

    sm83_alu_flags #(.WORD_SIZE(8)) dut (
        .clk(clk), .reset(reset), .alu_res(alu_res), .alu_cout(alu_cout),
        .alu_hcout(alu_hcout), .shift_out(shift_out), .daa_carry_out(daa_carry_out),
        .dbus(dbus), .flags_load(flags_load), .flags_we(flags_we), .z_clr(z_clr),
        .n_val(n_val), .h_src(h_src), .c_src(c_src), .pri_we(pri_we),
        .pri_clr(pri_clr), .cin_sel(cin_sel), .alu_cin(alu_cin), .zero(zero),
        .carry(carry), .pri_carry(pri_carry), .daa_carry(daa_carry),
        .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t   st_q[$];
    logic   cin_q[$];

    // Reference state: flag nibble {Z,N,H,C} and primary carry.
    logic [3:0] m_f = 4'h0;
    logic       m_pri = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Drive one cycle of stimulus and push what the spec says must follow.
    task automatic step(input stim_t s, input logic [3:0] gmask, input logic [3:0] gval);
        exp_t e;
        logic h_tab [4];
        logic c_tab [8];
        logic [3:0] wv;
        logic       cin_exp;
        @(posedge clk);
        #2;
        reset = s.rst; alu_res = s.res; alu_cout = s.cout; alu_hcout = s.hcout;
        shift_out = s.sh; daa_carry_out = s.daa; dbus = s.dbus; flags_load = s.load;
        flags_we = s.we; z_clr = s.zc; n_val = s.nv; h_src = s.hs; c_src = s.cs;
        pri_we = s.pwe; pri_clr = s.pclr; cin_sel = s.cin;

        cin_exp = (s.cin == 2'd0) ? 1'b0 : (s.cin == 2'd1) ? m_f[0] :
                  (s.cin == 2'd2) ? m_pri : 1'b1;
        cin_q.push_back(cin_exp);

        h_tab = '{s.hcout, 1'b0, 1'b1, !s.hcout};
        c_tab = '{s.cout, !s.cout, s.sh, s.daa | m_f[0], !m_f[0], 1'b1, m_f[0], m_f[0]};
        wv = {(s.res == 8'h00) && !s.zc, s.nv, h_tab[s.hs], c_tab[s.cs]};

        if (s.rst) begin
            m_f = 4'h0;
            m_pri = 1'b0;
        end else begin
            if (s.load) m_f = s.dbus[7:4];
            else        m_f = (m_f & ~s.we) | (wv & s.we);
            if (s.pclr)     m_pri = 1'b0;
            else if (s.pwe) m_pri = s.cout;
        end
        e.f = m_f; e.pri = m_pri; e.gmask = gmask; e.gval = gval;
        st_q.push_back(e);
    endtask

    // Registered outputs: compare just after the edge that consumed the stimulus.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("flags_out", flags_out, {e.f, 4'h0});
            chk("zero", {7'd0, zero}, {7'd0, e.f[3]});
            chk("daa_carry", {7'd0, daa_carry}, {7'd0, e.f[1]});
            chk("carry", {7'd0, carry}, {7'd0, e.f[0]});
            chk("pri_carry", {7'd0, pri_carry}, {7'd0, e.pri});
            if (e.gmask != 4'h0)
                chk("golden_flags", {4'h0, flags_out[7:4] & e.gmask}, {4'h0, e.gval & e.gmask});
        end
    end

    // Combinational carry-in: compare mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        logic c;
        if (cin_q.size() > 0) begin
            c = cin_q.pop_front();
            chk("alu_cin", {7'd0, alu_cin}, {7'd0, c});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        // Power-up reset.
        s = idle(); s.rst = 1'b1;
        step(s, 4'hF, 4'h0);
        step(s, 4'hF, 4'h0);

        // Load all-ones image and set primary carry, then reset overrides everything.
        s = idle(); s.load = 1'b1; s.dbus = 8'hF0; s.pwe = 1'b1; s.cout = 1'b1;
        step(s, 4'hF, 4'hF);
        s = idle(); s.rst = 1'b1; s.load = 1'b1; s.dbus = 8'hF0; s.we = 4'hF; s.pwe = 1'b1; s.cout = 1'b1;
        step(s, 4'hF, 4'h0);

        // ADD result 0x00 with both carries -> 0xB0.
        s = idle(); s.res = 8'h00; s.cout = 1'b1; s.hcout = 1'b1; s.we = 4'hF;
        step(s, 4'hF, 4'hB);

        // 16-bit chain: capture low-byte carry without touching C.
        s = idle(); s.pwe = 1'b1; s.cout = 1'b1; s.cin = 2'd1;
        step(s, 4'h1, 4'h1);
        s = idle(); s.cin = 2'd2; s.cout = 1'b0;
        step(s, 4'h1, 4'h1);
        s = idle(); s.pclr = 1'b1; s.pwe = 1'b1; s.cout = 1'b1; s.cin = 2'd2;
        step(s, 4'h0, 4'h0);
        s = idle(); s.cin = 2'd2;
        step(s, 4'h0, 4'h0);

        // SCF / CCF / DAA carry hold, starting from C=0.
        s = idle(); s.we = 4'h1; s.cs = 3'd1; s.cout = 1'b1;
        step(s, 4'h1, 4'h0);
        s = idle(); s.we = 4'h1; s.cs = 3'd5;
        step(s, 4'h1, 4'h1);
        s = idle(); s.we = 4'h1; s.cs = 3'd4;
        step(s, 4'h1, 4'h0);
        s = idle(); s.we = 4'h1; s.cs = 3'd5;
        step(s, 4'h1, 4'h1);
        s = idle(); s.we = 4'h1; s.cs = 3'd3; s.daa = 1'b0;
        step(s, 4'h1, 4'h1);

        // POP AF with conflicting per-flag sources and nonzero low nibble.
        s = idle(); s.load = 1'b1; s.dbus = 8'h5F; s.we = 4'hF; s.cs = 3'd4; s.hs = 2'd3; s.nv = 1'b0;
        step(s, 4'hF, 4'h5);

        // Selective writes.
        s = idle(); s.we = 4'h8; s.res = 8'h00; s.nv = 1'b1;
        step(s, 4'hF, 4'hD);
        s = idle(); s.we = 4'h4; s.nv = 1'b0; s.res = 8'h00;
        step(s, 4'hF, 4'h9);
        s = idle(); s.we = 4'h4; s.nv = 1'b1; s.res = 8'h00;
        step(s, 4'hF, 4'hD);
        s = idle(); s.we = 4'h8; s.zc = 1'b1; s.res = 8'h00;
        step(s, 4'h8, 4'h0);

        // Simultaneous primary capture and C write share alu_cout.
        s = idle(); s.pwe = 1'b1; s.we = 4'h1; s.cs = 3'd0; s.cout = 1'b1;
        step(s, 4'h1, 4'h1);
        s = idle(); s.cin = 2'd2;
        step(s, 4'h0, 4'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            s.rst   = ($urandom_range(0, 31) == 0);
            s.res   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            s.cout  = 1'($urandom);
            s.hcout = 1'($urandom);
            s.sh    = 1'($urandom);
            s.daa   = 1'($urandom);
            s.dbus  = 8'($urandom);
            s.load  = ($urandom_range(0, 7) == 0);
            s.we    = 4'($urandom);
            s.zc    = 1'($urandom);
            s.nv    = 1'($urandom);
            s.hs    = 2'($urandom);
            s.cs    = 3'($urandom);
            s.pwe   = 1'($urandom);
            s.pclr  = ($urandom_range(0, 3) == 0);
            s.cin   = 2'($urandom);
            step(s, 4'h0, 4'h0);
        end

        s = idle();
        step(s, 4'h0, 4'h0);
        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (st_q.size() != 0 || cin_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", st_q.size(), cin_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
